// File: rtl/settle_monitor_pkg.sv
// Shared definitions for the step-response settle monitor.
//   state_t      : FSM encoding (IDLE, MEASURE, DONE)
//   CNT_ALL_ONES : settle_cycles value reported on timeout at the default counter width
//   sat_max()    : largest positive value of a signed word of a given width
package settle_monitor_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MEASURE = 2'd1,
        DONE    = 2'd2
    } state_t;

    localparam int unsigned DEF_CNT_WIDTH = 16;
    localparam logic [DEF_CNT_WIDTH-1:0] CNT_ALL_ONES = {DEF_CNT_WIDTH{1'b1}};

    // 2^(width-1)-1, the saturation ceiling for an unsigned excursion stored in a signed-width field
    function automatic logic [63:0] sat_max(input int unsigned width);
        return (64'd1 << (width - 32'd1)) - 64'd1;
    endfunction

endpackage

// File: rtl/settle_band_cmp.sv
// Combinational band comparator for the settle monitor.
//   v_in, target, tol : signed fixed-point words (tol expected >= 0)
//   in_band           : |v_in - target| <= tol
//   below_target      : v_in < target
// The difference is formed one bit wider than the inputs so it cannot overflow.
module settle_band_cmp #(
    parameter int WIDTH = 25
) (
    input  logic signed [WIDTH-1:0] v_in,
    input  logic signed [WIDTH-1:0] target,
    input  logic signed [WIDTH-1:0] tol,
    output logic                    in_band,
    output logic                    below_target
);

    logic signed [WIDTH:0] diff_s;
    logic        [WIDTH:0] mag_s;

    // Widened difference, magnitude and band decision
    always_comb begin
        diff_s = $signed({v_in[WIDTH-1], v_in}) - $signed({target[WIDTH-1], target});
        if (diff_s[WIDTH]) begin
            mag_s = $unsigned(-diff_s);
        end else begin
            mag_s = $unsigned(diff_s);
        end
        // A negative tolerance is meaningless; treat it as an empty band.
        in_band      = !tol[WIDTH-1] && (mag_s <= {1'b0, tol});
        below_target = diff_s[WIDTH];
    end

endmodule

// File: rtl/settle_monitor.sv
// Step-response checker downstream of the filter.
// After an accepted start it measures settling time (start of the final in-band
// run of HOLD_CYCLES samples), peak excursion in the step direction, overshoot
// beyond target, or a timeout after TIMEOUT measurement cycles.
//   clk, rst (sync, active high), start (accepted when not busy)
//   v_in, target, tol : signed fixed-point; target/tol captured on start
//   busy, done (1-cycle pulse), settled, timed_out, settle_cycles, peak, overshoot
module settle_monitor
    import settle_monitor_pkg::*;
#(
    parameter int WIDTH       = 25,
    parameter int EXPONENT    = -20,
    parameter int HOLD_CYCLES = 16,
    parameter int TIMEOUT     = 50000,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic signed [WIDTH-1:0] v_in,
    input  logic signed [WIDTH-1:0] target,
    input  logic signed [WIDTH-1:0] tol,
    output logic                    busy,
    output logic                    done,
    output logic                    settled,
    output logic                    timed_out,
    output logic [CNT_WIDTH-1:0]    settle_cycles,
    output logic signed [WIDTH-1:0] peak,
    output logic [WIDTH-1:0]        overshoot
);

    localparam logic [WIDTH:0]       SAT_W     = (WIDTH+1)'(sat_max(WIDTH));
    localparam logic [CNT_WIDTH-1:0] CNT_ONE   = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CNT_WIDTH-1:0] CNT_ONES  = {CNT_WIDTH{1'b1}};
    localparam logic [CNT_WIDTH-1:0] HOLD_C    = CNT_WIDTH'(HOLD_CYCLES);
    localparam logic [CNT_WIDTH-1:0] K_LAST    = CNT_WIDTH'(TIMEOUT - 1);

    // All arithmetic is scale-free; the exponent only documents the port scaling.
    if (EXPONENT > 0) begin : g_integer_scaling
    end

    state_t                  state_r;
    logic                    busy_r, done_r, settled_r, timed_out_r;
    logic [CNT_WIDTH-1:0]    settle_cycles_r;
    logic signed [WIDTH-1:0] peak_out_r;
    logic [WIDTH-1:0]        overshoot_r;
    logic signed [WIDTH-1:0] target_r, tol_r, peak_r;
    logic [CNT_WIDTH-1:0]    k_r, hold_r, entry_r;
    logic                    rising_r;

    logic                    in_band_s, below_s, first_s, rising_now_s;
    logic                    settle_s, timeout_s;
    logic signed [WIDTH-1:0] peak_nxt_s;
    logic [CNT_WIDTH-1:0]    hold_inc_s, entry_now_s;
    logic signed [WIDTH:0]   exc_s;
    logic [WIDTH-1:0]        overshoot_nxt_s;

    settle_band_cmp #(.WIDTH(WIDTH)) u_cmp (
        .v_in         (v_in),
        .target       (target_r),
        .tol          (tol_r),
        .in_band      (in_band_s),
        .below_target (below_s)
    );

    // Per-sample decisions: direction, running peak, hold/entry bookkeeping, overshoot
    always_comb begin
        first_s      = (k_r == '0);
        rising_now_s = first_s ? below_s : rising_r;
        if (first_s) begin
            peak_nxt_s = v_in;
        end else if (rising_now_s) begin
            peak_nxt_s = (v_in > peak_r) ? v_in : peak_r;
        end else begin
            peak_nxt_s = (v_in < peak_r) ? v_in : peak_r;
        end
        hold_inc_s  = hold_r + CNT_ONE;
        // When this sample opens the run, the run starts at k itself.
        entry_now_s = (hold_r == '0) ? k_r : entry_r;
        settle_s    = in_band_s && (hold_inc_s == HOLD_C);
        timeout_s   = !settle_s && (k_r == K_LAST);
        if (rising_now_s) begin
            exc_s = $signed({peak_nxt_s[WIDTH-1], peak_nxt_s}) - $signed({target_r[WIDTH-1], target_r});
        end else begin
            exc_s = $signed({target_r[WIDTH-1], target_r}) - $signed({peak_nxt_s[WIDTH-1], peak_nxt_s});
        end
        if (exc_s[WIDTH]) begin
            overshoot_nxt_s = '0;
        end else if ($unsigned(exc_s) > SAT_W) begin
            overshoot_nxt_s = SAT_W[WIDTH-1:0];
        end else begin
            overshoot_nxt_s = exc_s[WIDTH-1:0];
        end
    end

    // FSM, measurement counters and result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r         <= IDLE;
            busy_r          <= 1'b0;
            done_r          <= 1'b0;
            settled_r       <= 1'b0;
            timed_out_r     <= 1'b0;
            settle_cycles_r <= '0;
            peak_out_r      <= '0;
            overshoot_r     <= '0;
            target_r        <= '0;
            tol_r           <= '0;
            peak_r          <= '0;
            k_r             <= '0;
            hold_r          <= '0;
            entry_r         <= '0;
            rising_r        <= 1'b0;
        end else begin
            case (state_r)
                IDLE, DONE: begin
                    done_r <= 1'b0;
                    if (start) begin
                        state_r         <= MEASURE;
                        busy_r          <= 1'b1;
                        target_r        <= target;
                        tol_r           <= tol;
                        settled_r       <= 1'b0;
                        timed_out_r     <= 1'b0;
                        settle_cycles_r <= '0;
                        peak_out_r      <= '0;
                        overshoot_r     <= '0;
                        peak_r          <= '0;
                        k_r             <= '0;
                        hold_r          <= '0;
                        entry_r         <= '0;
                    end else begin
                        state_r <= IDLE;
                        busy_r  <= 1'b0;
                    end
                end
                MEASURE: begin
                    hold_r   <= in_band_s ? hold_inc_s : '0;
                    entry_r  <= in_band_s ? entry_now_s : entry_r;
                    peak_r   <= peak_nxt_s;
                    rising_r <= rising_now_s;
                    k_r      <= k_r + CNT_ONE;
                    if (settle_s || timeout_s) begin
                        state_r         <= DONE;
                        busy_r          <= 1'b0;
                        done_r          <= 1'b1;
                        settled_r       <= settle_s;
                        timed_out_r     <= !settle_s;
                        settle_cycles_r <= settle_s ? entry_now_s : CNT_ONES;
                        peak_out_r      <= peak_nxt_s;
                        overshoot_r     <= overshoot_nxt_s;
                    end else begin
                        state_r <= MEASURE;
                        busy_r  <= 1'b1;
                        done_r  <= 1'b0;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                end
            endcase
        end
    end

    assign busy          = busy_r;
    assign done          = done_r;
    assign settled       = settled_r;
    assign timed_out     = timed_out_r;
    assign settle_cycles = settle_cycles_r;
    assign peak          = peak_out_r;
    assign overshoot     = overshoot_r;

endmodule
